// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode encodings and the fetch state enum used by
// the fetch stage and the control unit downstream of it.
package cpu_pkg;

  localparam int PC_WIDTH     = 8;
  localparam int INST_WIDTH   = 8;
  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_J   = 4'b1000;
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL = 4'b1001;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = 4'b1100;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE = 4'b1101;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(input logic [INST_WIDTH-1:0] word);
    return word[INST_WIDTH-1 -: OPCODE_WIDTH];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, fetches one instruction
// at a time from instruction memory (req/ready) and presents it to the
// control unit (valid/accept). Redirects replace the PC; a fetch that is
// already outstanding when a redirect arrives is completed and thrown away.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   imem_req/imem_addr         fetch request and address (registered)
//   imem_ready/imem_rdata      memory completion and returned instruction
//   inst/inst_valid/inst_pc    instruction register toward the control unit
//   link_pc                    inst_pc + 1, jal return address
//   inst_accept                control unit consumes inst
//   redirect_valid/redirect_pc PC change request from the control unit
//
// state    | meaning
// ---------+----------------------------------------------------------
// BOOT     | one idle cycle after reset, no request
// FETCH    | request outstanding at req_addr, result will be kept
// FULL     | inst holds a live instruction, waiting for accept
// DRAIN    | stale request outstanding, result will be discarded
module fetch_unit #(
  parameter int PC_WIDTH   = cpu_pkg::PC_WIDTH,
  parameter int INST_WIDTH = cpu_pkg::INST_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ready,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  inst_accept,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic [PC_WIDTH-1:0]   link_pc,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc
);

  import cpu_pkg::*;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   req_addr;

  assign imem_addr = req_addr;

  // imem_req, inst_valid and link_pc are kept as flops updated alongside the
  // state so that no output depends combinationally on an input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      link_pc    <= PC_ONE;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end

        ST_FETCH: begin
          if (imem_ready && !redirect_valid) begin
            inst       <= imem_rdata;
            inst_pc    <= req_addr;
            link_pc    <= req_addr + PC_ONE;
            pc         <= req_addr + PC_ONE;
            state      <= ST_FULL;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end else if (imem_ready && redirect_valid) begin
            // Request just completed, so the new target can issue at once.
            pc       <= redirect_pc;
            req_addr <= redirect_pc;
          end else if (redirect_valid) begin
            // Address must stay put until memory finishes the old request.
            pc    <= redirect_pc;
            state <= ST_DRAIN;
          end
        end

        ST_FULL: begin
          if (redirect_valid) begin
            pc         <= redirect_pc;
            req_addr   <= redirect_pc;
            state      <= ST_FETCH;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
          end else if (inst_accept) begin
            req_addr   <= pc;
            state      <= ST_FETCH;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          if (imem_ready) begin
            // A redirect landing on the completing cycle is the latest target.
            req_addr <= redirect_valid ? redirect_pc : pc;
            state    <= ST_FETCH;
          end
        end

        default: begin
          state      <= ST_BOOT;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
